alu_seq_ctrl: RTL and testbench

// - Multi-cycle instruction sequencer for the 4-bit combinational ALU (8 ops, sel[2:0]).
// - Owns a 4 x 4-bit register file and accepts one instruction at a time over a valid/ready handshake.
// - Reads operands, drives the ALU ports and holds them for SETTLE_CYCLES, then captures the result and writes it back.
// - Sits between the switch/button front end and the ALU + 7-segment output path.

---
 rtl/alu_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-cycle instruction sequencer for a 4-bit combinational ALU
//
// Purpose:
//   Accepts one 10-bit instruction at a time over in_valid/in_ready, reads
//   operands from a 4 x 4-bit register file, drives the ALU and holds its
//   inputs for SETTLE_CYCLES, captures alu_rd and writes it back. Load-
//   immediate (li) skips the ALU and writes the immediate directly.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   instruction handshake; in_ready is high only in IDLE
//   in_instr[9:0]       [9]=li [8:6]=sel [5:4]=rd [3:2]=rs [1:0]=rt, imm=[3:0]
//   alu_rs/alu_rt/alu_sel  registered operands/opcode to the ALU
//   alu_rd              combinational ALU result
//   wb_valid/wb_idx/wb_data  write-back pulse, destination and data
//   busy                high whenever not IDLE
//   op_count            completed write-backs, wraps modulo 256
//   dbg_idx/dbg_data    combinational register-file debug read

module alu_seq_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [9:0] in_instr,
  output logic [3:0] alu_rs,
  output logic [3:0] alu_rt,
  output logic [2:0] alu_sel,
  input  logic [3:0] alu_rd,
  output logic       wb_valid,
  output logic [1:0] wb_idx,
  output logic [3:0] wb_data,
  output logic       busy,
  output logic [7:0] op_count,
  input  logic [1:0] dbg_idx,
  output logic [3:0] dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_SETTLE, S_WB} state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] sel_q;
  logic [1:0] rs_idx_q;
  logic [1:0] rt_idx_q;
  logic [3:0] cnt_q;
  logic [3:0] rf_q [4];
  logic [3:0] alu_rs_q, alu_rt_q;
  logic [2:0] alu_sel_q;
  logic [1:0] wb_idx_q;
  logic [3:0] wb_data_q;
  logic [7:0] op_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    wb_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = in_instr[9] ? S_WB : S_READ;
      end
      S_READ:   state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == 4'd0) state_d = S_WB;
      S_WB: begin
        wb_valid = 1'b1;
        state_d  = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q      <= '0;
      rs_idx_q   <= '0;
      rt_idx_q   <= '0;
      cnt_q      <= '0;
      alu_rs_q   <= '0;
      alu_rt_q   <= '0;
      alu_sel_q  <= '0;
      wb_idx_q   <= '0;
      wb_data_q  <= '0;
      op_count_q <= '0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          sel_q    <= in_instr[8:6];
          wb_idx_q <= in_instr[5:4];
          rs_idx_q <= in_instr[3:2];
          rt_idx_q <= in_instr[1:0];
          // li goes straight to WB, so its immediate is staged now
          if (in_instr[9]) wb_data_q <= in_instr[3:0];
        end
        S_READ: begin
          alu_rs_q  <= rf_q[rs_idx_q];
          alu_rt_q  <= rf_q[rt_idx_q];
          alu_sel_q <= sel_q;
          cnt_q     <= SETTLE_M1;
        end
        S_SETTLE: begin
          if (cnt_q == 4'd0) wb_data_q <= alu_rd;
          else               cnt_q     <= cnt_q - 4'd1;
        end
        S_WB: begin
          rf_q[wb_idx_q] <= wb_data_q;
          op_count_q     <= op_count_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign alu_rs   = alu_rs_q;
  assign alu_rt   = alu_rt_q;
  assign alu_sel  = alu_sel_q;
  assign wb_idx   = wb_idx_q;
  assign wb_data  = wb_data_q;
  assign op_count = op_count_q;
  assign dbg_data = rf_q[dbg_idx];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - self-checking bench for alu_seq_ctrl at SETTLE_CYCLES 2, 1 and 15
//
// Three instances share clock, reset, instruction and debug index. Instance 0
// (S=2) also runs a back-to-back sequence alone; instances 1 (S=1) and
// 2 (S=15) only see in_valid when aux_en is set. Each has its own ALU model.

module tb_alu_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       aux_en;
  logic       vld_aux;
  logic [9:0] in_instr;
  logic [1:0] dbg_idx;

  logic       in_ready [3];
  logic [3:0] alu_rs   [3];
  logic [3:0] alu_rt   [3];
  logic [2:0] alu_sel  [3];
  logic [3:0] alu_rd   [3];
  logic       wb_valid [3];
  logic [1:0] wb_idx   [3];
  logic [3:0] wb_data  [3];
  logic       busy     [3];
  logic [7:0] op_count [3];
  logic [3:0] dbg_data [3];

  int errors = 0;
  int checks = 0;

  logic [3:0] ref_rf [4];
  logic [7:0] ref_cnt;

  function automatic logic [3:0] alu_f(input logic [2:0] sel, input logic [3:0] a, input logic [3:0] b);
    case (sel)
      3'd0: return a - b;
      3'd1: return a + b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return {3'b000, a < b};
      default: return {3'b000, a == b};
    endcase
  endfunction

  function automatic int sc(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  assign vld_aux   = in_valid & aux_en;
  assign alu_rd[0] = alu_f(alu_sel[0], alu_rs[0], alu_rt[0]);
  assign alu_rd[1] = alu_f(alu_sel[1], alu_rs[1], alu_rt[1]);
  assign alu_rd[2] = alu_f(alu_sel[2], alu_rs[2], alu_rt[2]);

  alu_seq_ctrl #(.SETTLE_CYCLES(2)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .in_instr(in_instr),
    .alu_rs(alu_rs[0]), .alu_rt(alu_rt[0]), .alu_sel(alu_sel[0]), .alu_rd(alu_rd[0]),
    .wb_valid(wb_valid[0]), .wb_idx(wb_idx[0]), .wb_data(wb_data[0]), .busy(busy[0]),
    .op_count(op_count[0]), .dbg_idx(dbg_idx), .dbg_data(dbg_data[0]));

  alu_seq_ctrl #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(vld_aux), .in_ready(in_ready[1]), .in_instr(in_instr),
    .alu_rs(alu_rs[1]), .alu_rt(alu_rt[1]), .alu_sel(alu_sel[1]), .alu_rd(alu_rd[1]),
    .wb_valid(wb_valid[1]), .wb_idx(wb_idx[1]), .wb_data(wb_data[1]), .busy(busy[1]),
    .op_count(op_count[1]), .dbg_idx(dbg_idx), .dbg_data(dbg_data[1]));

  alu_seq_ctrl #(.SETTLE_CYCLES(15)) u_s15 (
    .clk(clk), .rst(rst), .in_valid(vld_aux), .in_ready(in_ready[2]), .in_instr(in_instr),
    .alu_rs(alu_rs[2]), .alu_rt(alu_rt[2]), .alu_sel(alu_sel[2]), .alu_rd(alu_rd[2]),
    .wb_valid(wb_valid[2]), .wb_idx(wb_idx[2]), .wb_data(wb_data[2]), .busy(busy[2]),
    .op_count(op_count[2]), .dbg_idx(dbg_idx), .dbg_data(dbg_data[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string pfx);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_k%0d_in_ready", pfx, k), in_ready[k], 1);
      chk($sformatf("%s_k%0d_busy", pfx, k), busy[k], 0);
      chk($sformatf("%s_k%0d_wb_valid", pfx, k), wb_valid[k], 0);
      chk($sformatf("%s_k%0d_wb_idx", pfx, k), wb_idx[k], 0);
      chk($sformatf("%s_k%0d_wb_data", pfx, k), wb_data[k], 0);
      chk($sformatf("%s_k%0d_op_count", pfx, k), op_count[k], 0);
      chk($sformatf("%s_k%0d_alu_rs", pfx, k), alu_rs[k], 0);
      chk($sformatf("%s_k%0d_alu_rt", pfx, k), alu_rt[k], 0);
      chk($sformatf("%s_k%0d_alu_sel", pfx, k), alu_sel[k], 0);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_idx = 2'(i);
      #1;
      for (int k = 0; k < 3; k++)
        chk($sformatf("%s_k%0d_r%0d", pfx, k, i), dbg_data[k], 0);
    end
  endtask

  // Issues one instruction to all three instances and checks every cycle of
  // the following 20 against the latency and write-back rules.
  task automatic exec(input bit li, input logic [2:0] sel, input logic [1:0] rd,
                      input logic [1:0] rs, input logic [1:0] rt, input logic [3:0] imm);
    logic [3:0] exp;
    logic [3:0] old_rd;
    int lat [3];
    int w;
    @(negedge clk);
    w = 0;
    while (!(in_ready[0] && in_ready[1] && in_ready[2])) begin
      @(negedge clk);
      w++;
      if (w > 50) begin
        chk("idle_timeout", 0, 1);
        break;
      end
    end
    exp    = li ? imm : alu_f(sel, ref_rf[rs], ref_rf[rt]);
    old_rd = ref_rf[rd];
    for (int k = 0; k < 3; k++) lat[k] = li ? 1 : 2 + sc(k);
    dbg_idx  = rd;
    in_instr = li ? {1'b1, sel, rd, imm} : {1'b0, sel, rd, rs, rt};
    aux_en   = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("k%0d_n%0d_wb_valid", k, n), wb_valid[k], (n == lat[k]));
        if (n <= lat[k]) begin
          chk($sformatf("k%0d_n%0d_in_ready_low", k, n), in_ready[k], 0);
          chk($sformatf("k%0d_n%0d_busy", k, n), busy[k], 1);
        end
        if (n == lat[k]) begin
          chk($sformatf("k%0d_wb_idx", k), wb_idx[k], rd);
          chk($sformatf("k%0d_wb_data", k), wb_data[k], exp);
          chk($sformatf("k%0d_dbg_old", k), dbg_data[k], old_rd);
        end
        if (n == lat[k] + 1) begin
          chk($sformatf("k%0d_in_ready_back", k), in_ready[k], 1);
          chk($sformatf("k%0d_dbg_new", k), dbg_data[k], exp);
          chk($sformatf("k%0d_op_count", k), op_count[k], 8'(ref_cnt + 8'd1));
        end
        if (!li && n >= 2 && n <= 1 + sc(k)) begin
          chk($sformatf("k%0d_n%0d_alu_rs", k, n), alu_rs[k], ref_rf[rs]);
          chk($sformatf("k%0d_n%0d_alu_rt", k, n), alu_rt[k], ref_rf[rt]);
          chk($sformatf("k%0d_n%0d_alu_sel", k, n), alu_sel[k], sel);
        end
      end
    end
    ref_rf[rd] = exp;
    ref_cnt    = ref_cnt + 8'd1;
  endtask

  task automatic check_reg_lit(input string tag, input logic [1:0] idx, input logic [3:0] val);
    dbg_idx = idx;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("%s_k%0d", tag, k), dbg_data[k], val);
  endtask

  initial begin
    logic [9:0] ins_a, ins_b;
    logic [3:0] exp_a, exp_b;
    int acc_n;
    int pulses;
    rst      = 1'b1;
    in_valid = 1'b0;
    aux_en   = 1'b1;
    in_instr = '0;
    dbg_idx  = '0;
    for (int i = 0; i < 4; i++) ref_rf[i] = 4'd0;
    ref_cnt = 8'd0;
    #12;
    check_reset_state("por");
    @(negedge clk);
    rst = 1'b0;

    // Directed arithmetic
    exec(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd5);
    exec(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 4'd3);
    exec(1'b0, 3'd1, 2'd3, 2'd1, 2'd2, 4'd0);
    check_reg_lit("add_r3", 2'd3, 4'd8);
    exec(1'b0, 3'd0, 2'd0, 2'd2, 2'd1, 4'd0);
    check_reg_lit("sub_r0", 2'd0, 4'hE);
    exec(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd9);
    exec(1'b0, 3'd1, 2'd1, 2'd1, 2'd1, 4'd0);
    check_reg_lit("add_wrap_r1", 2'd1, 4'd2);
    exec(1'b0, 3'd7, 2'd2, 2'd3, 2'd3, 4'd0);
    check_reg_lit("eq_r2", 2'd2, 4'd1);

    // Random instructions
    for (int i = 0; i < 24; i++)
      exec(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));

    // Back-to-back on the S=2 instance with in_valid held high
    @(negedge clk);
    aux_en = 1'b0;
    ins_a  = {1'b0, 3'd1, 2'd1, 2'd2, 2'd3};
    ins_b  = {1'b0, 3'd0, 2'd2, 2'd1, 2'd0};
    exp_a  = alu_f(3'd1, ref_rf[2], ref_rf[3]);
    ref_rf[1] = exp_a;
    exp_b  = alu_f(3'd0, ref_rf[1], ref_rf[0]);
    ref_rf[2] = exp_b;
    in_instr = ins_a;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_instr = ins_b;
    acc_n  = 0;
    pulses = 0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (wb_valid[0]) begin
        chk($sformatf("b2b_wb_data_%0d", pulses), wb_data[0], (pulses == 0) ? exp_a : exp_b);
        pulses++;
      end
      if (in_valid && in_ready[0]) begin
        acc_n = n;
        @(posedge clk);
        #1 in_valid = 1'b0;
      end
    end
    chk("b2b_second_accept_cycle", acc_n, 5);
    chk("b2b_pulses", pulses, 2);
    chk("b2b_op_count", op_count[0], 8'(ref_cnt + 8'd2));
    aux_en = 1'b1;

    // Reset during SETTLE
    @(negedge clk);
    in_instr = {1'b0, 3'd1, 2'd0, 2'd1, 2'd2};
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("pre_rst_k%0d_busy", k), busy[k], 1);
    #1 rst = 1'b1;
    #1;
    check_reset_state("midrst");
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("rst_held_k%0d_in_ready", k), in_ready[k], 1);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (wb_valid[k]) pulses++;
    end
    chk("post_rst_no_wb", pulses, 0);
    for (int i = 0; i < 4; i++) ref_rf[i] = 4'd0;
    ref_cnt = 8'd0;

    // Latency at S=1 and S=15 alongside S=2, then op_count wrap
    exec(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd7);
    exec(1'b0, 3'd4, 2'd3, 2'd0, 2'd0, 4'd0);
    for (int i = 0; i < 254; i++)
      exec(1'b1, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'd0, 2'd0,
           4'($urandom_range(0, 15)));
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("wrap_k%0d_op_count", k), op_count[k], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
